// File: rtl/prbs9_checker.sv
// prbs9_checker
//   Receive-side PRBS9 (x^9 + x^5 + 1) checker. Self-synchronises to the
//   incoming serial stream, then runs as a flywheel and flags/counts bit
//   errors for BER measurement. One bit is consumed per i_enable strobe.
//
// Ports
//   clock        system clock, all logic on posedge
//   i_reset      asynchronous, active-high reset
//   i_bit        received PRBS bit
//   i_enable     i_bit valid, sampled on posedge
//   i_clear      synchronous clear of both counters (priority over increment)
//   o_locked     checker synchronised to the sequence
//   o_error      one-cycle pulse: last sampled bit mismatched while locked
//   o_err_count  saturating mismatch count since lock/clear
//   o_bit_count  saturating count of bits checked while locked since lock/clear
//
// Optional feature macro: PRBS9_CHK_LOSS_DETECT_EN
//   When defined, LOCKED tracks errors per LOSS_WINDOW-bit window and drops
//   back to SEARCH as soon as a window accumulates LOSS_THRESH errors.
//   When undefined, LOCKED is held until i_reset.

module prbs9_checker #(
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned ERR_W       = 32,
    parameter int unsigned BIT_W       = 32,
    parameter int unsigned LOSS_WINDOW = 128,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_bit,
    input  logic             i_enable,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [ERR_W-1:0] o_err_count,
    output logic [BIT_W-1:0] o_bit_count
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    if (LOCK_COUNT < 1 || ERR_W < 1 || BIT_W < 1 ||
        LOSS_THRESH < 1 || LOSS_WINDOW < LOSS_THRESH) begin : g_param_check
        $error("prbs9_checker: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       hist_q, hist_d;     // bit 0 = newest (h[1]), bit 8 = oldest (h[9])
    logic [3:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic             error_q, error_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             pred;
    logic             mismatch;

`ifdef PRBS9_CHK_LOSS_DETECT_EN
    localparam int unsigned WW = $clog2(LOSS_WINDOW + 1);
    localparam int unsigned TW = $clog2(LOSS_THRESH + 1);

    logic [WW-1:0] win_bits_q, win_bits_d;
    logic [TW-1:0] win_errs_q, win_errs_d;
`endif

    assign pred     = hist_q[8] ^ hist_q[4];
    assign mismatch = i_bit ^ pred;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        error_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PRBS9_CHK_LOSS_DETECT_EN
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
`endif

        if (i_enable) begin
            case (state_q)
                ST_SEARCH: begin
                    hist_d = {hist_q[7:0], i_bit};
                    if (fill_q == 4'd8) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end

                ST_VERIFY: begin
                    hist_d = {hist_q[7:0], i_bit};
                    // An all-zero history predicts zeros forever; refuse to count it.
                    if (hist_q == '0 || mismatch) begin
                        match_d = '0;
                    end else if (match_q == MW'(LOCK_COUNT - 1)) begin
                        state_d   = ST_LOCKED;
                        match_d   = '0;
                        err_cnt_d = '0;
                        bit_cnt_d = '0;
`ifdef PRBS9_CHK_LOSS_DETECT_EN
                        win_bits_d = '0;
                        win_errs_d = '0;
`endif
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    // Flywheel: feed back the prediction so a single channel
                    // error is not re-seen as the bit ages through the history.
                    hist_d = {hist_q[7:0], pred};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
`ifdef PRBS9_CHK_LOSS_DETECT_EN
                    if (mismatch && win_errs_q == TW'(LOSS_THRESH - 1)) begin
                        state_d    = ST_SEARCH;
                        fill_d     = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else if (win_bits_q == WW'(LOSS_WINDOW - 1)) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = win_bits_q + 1'b1;
                        if (mismatch) begin
                            win_errs_d = win_errs_q + 1'b1;
                        end
                    end
`endif
                end

                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        if (i_clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_SEARCH;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

`ifdef PRBS9_CHK_LOSS_DETECT_EN
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            win_bits_q <= '0;
            win_errs_q <= '0;
        end else begin
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
        end
    end
`endif

    assign o_locked    = (state_q == ST_LOCKED);
    assign o_error     = error_q;
    assign o_err_count = err_cnt_q;
    assign o_bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// tb_prbs9_checker
//   Directed bench for prbs9_checker at default parameters. A reference
//   PRBS9 generator (seed 'h1AA) supplies the stream; a vector table drives
//   the main lock / count / error / clear flow, and hand-written sequences
//   cover sparse enables, all-zero input, loss of lock and async reset.

module tb_prbs9_checker;

    logic        clock;
    logic        i_reset;
    logic        i_bit;
    logic        i_enable;
    logic        i_clear;
    logic        o_locked;
    logic        o_error;
    logic [31:0] o_err_count;
    logic [31:0] o_bit_count;

    int unsigned checks;
    int unsigned failures;
    logic [8:0]  gen;

    prbs9_checker dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_bit       (i_bit),
        .i_enable    (i_enable),
        .i_clear     (i_clear),
        .o_locked    (o_locked),
        .o_error     (o_error),
        .o_err_count (o_err_count),
        .o_bit_count (o_bit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned nbits;
        bit          inv_last;
        bit          clr_last;
        bit          exp_locked;
        bit          exp_error;
        int unsigned exp_err;
        int unsigned exp_bits;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Next bit of the reference generator: x[n] = x[n-9] ^ x[n-5].
    task automatic gen_bit(output logic b);
        b   = gen[8] ^ gen[4];
        gen = {gen[7:0], b};
    endtask

    task automatic step(input logic en, input logic b, input logic clr);
        i_enable = en;
        i_bit    = b;
        i_clear  = clr;
        @(posedge clock);
        #1;
        i_enable = 1'b0;
        i_clear  = 1'b0;
    endtask

    task automatic send_clean(input int unsigned n);
        logic b;
        for (int unsigned k = 0; k < n; k++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_clear  = 1'b0;
        i_bit    = 1'b0;
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        gen     = 9'h1AA;
    endtask

    initial begin
        logic        b;
        int unsigned valid;
        int unsigned lock_at;
        bit          any_lock;

        checks   = 0;
        failures = 0;
        gen      = 9'h1AA;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_clear  = 1'b0;
        i_bit    = 1'b0;
        #2;
        chk("reset_locked", {63'd0, o_locked}, 64'd0);
        chk("reset_error", {63'd0, o_error}, 64'd0);
        chk("reset_err_count", {32'd0, o_err_count}, 64'd0);
        chk("reset_bit_count", {32'd0, o_bit_count}, 64'd0);
        do_reset();

        // nbits, inv_last, clr_last, exp_locked, exp_error, exp_err, exp_bits
        tbl[0] = '{24,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1,    1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[2] = '{1000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1000};
        tbl[3] = '{1,    1'b1, 1'b0, 1'b1, 1'b1, 1, 1001};
        tbl[4] = '{1,    1'b0, 1'b0, 1'b1, 1'b0, 1, 1002};
        tbl[5] = '{1,    1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[6] = '{10,   1'b0, 1'b0, 1'b1, 1'b0, 0, 10};

        for (int i = 0; i < 7; i++) begin
            for (int unsigned k = 0; k < tbl[i].nbits; k++) begin
                bit last;
                last = (k == tbl[i].nbits - 1);
                gen_bit(b);
                step(1'b1, b ^ (last & tbl[i].inv_last), last & tbl[i].clr_last);
            end
            chk($sformatf("vec%0d_locked", i), {63'd0, o_locked}, {63'd0, tbl[i].exp_locked});
            chk($sformatf("vec%0d_error", i), {63'd0, o_error}, {63'd0, tbl[i].exp_error});
            chk($sformatf("vec%0d_err_count", i), {32'd0, o_err_count}, {32'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_bit_count", i), {32'd0, o_bit_count}, {32'd0, tbl[i].exp_bits});
        end

        // Async reset while locked with an error pulse showing, no clock edge.
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
        chk("prereset_error", {63'd0, o_error}, 64'd1);
        chk("prereset_err_count", {32'd0, o_err_count}, 64'd1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("async_rst_locked", {63'd0, o_locked}, 64'd0);
        chk("async_rst_error", {63'd0, o_error}, 64'd0);
        chk("async_rst_err_count", {32'd0, o_err_count}, 64'd0);
        chk("async_rst_bit_count", {32'd0, o_bit_count}, 64'd0);
        i_reset = 1'b0;
        send_clean(24);
        chk("relock_24_locked", {63'd0, o_locked}, 64'd0);
        send_clean(1);
        chk("relock_25_locked", {63'd0, o_locked}, 64'd1);

        // Sparse enables with junk on i_bit between strobes.
        do_reset();
        valid   = 0;
        lock_at = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc % 3 == 0) begin
                gen_bit(b);
                step(1'b1, b, 1'b0);
                valid++;
            end else begin
                step(1'b0, 1'($urandom), 1'b0);
            end
            if (o_locked && lock_at == 0) lock_at = valid;
        end
        chk("sparse_lock_bit", {32'd0, lock_at}, 64'd25);
        chk("sparse_err_count", {32'd0, o_err_count}, 64'd0);
        chk("sparse_bit_count", {32'd0, o_bit_count}, 64'd75);

        // All-zero stream never locks.
        do_reset();
        any_lock = 1'b0;
        for (int k = 0; k < 500; k++) begin
            step(1'b1, 1'b0, 1'b0);
            any_lock |= o_locked;
        end
        chk("zeros_never_lock", {63'd0, any_lock}, 64'd0);

        // 8 errors inside one window.
        do_reset();
        send_clean(25);
        chk("loss_pre_locked", {63'd0, o_locked}, 64'd1);
        for (int k = 0; k < 15; k++) begin
            gen_bit(b);
            step(1'b1, b ^ (k % 2 == 0), 1'b0);
            if (k == 12) chk("loss_7th_err_locked", {63'd0, o_locked}, 64'd1);
        end
        chk("loss_err_count", {32'd0, o_err_count}, 64'd8);
`ifdef PRBS9_CHK_LOSS_DETECT_EN
        chk("loss_8th_err_locked", {63'd0, o_locked}, 64'd0);
        send_clean(24);
        chk("loss_relock_24", {63'd0, o_locked}, 64'd0);
        chk("loss_hold_err_count", {32'd0, o_err_count}, 64'd8);
        send_clean(1);
        chk("loss_relock_25", {63'd0, o_locked}, 64'd1);
        chk("loss_relock_err_count", {32'd0, o_err_count}, 64'd0);
`else
        chk("noloss_locked", {63'd0, o_locked}, 64'd1);
        send_clean(30);
        chk("noloss_still_locked", {63'd0, o_locked}, 64'd1);
        chk("noloss_err_count", {32'd0, o_err_count}, 64'd8);
        chk("noloss_bit_count", {32'd0, o_bit_count}, 64'd45);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
